// File: rtl/data_memory_ctrl.sv
// data_memory_ctrl: single-outstanding load/store controller over a DEPTH x 32-bit
// word array. Requests are captured in IDLE, held for LATENCY+1 edges, and then
// executed on the edge that enters RESP. The response is held until it is consumed.
module data_memory_ctrl #(
    parameter int DEPTH   = 128,
    parameter int LATENCY = 1
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic        i_req_valid,
    output logic        o_req_ready,
    input  logic        i_req_we,
    input  logic [1:0]  i_req_size,
    input  logic        i_req_unsigned,
    input  logic [31:0] i_req_addr,
    input  logic [31:0] i_req_wdata,
    output logic        o_rsp_valid,
    input  logic        i_rsp_ready,
    output logic [31:0] o_rsp_rdata,
    output logic        o_rsp_err,
    output logic        o_busy
);
    localparam int         AW  = $clog2(DEPTH);
    localparam logic [3:0] LAT = 4'(LATENCY);

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;

    state_t      r_state;
    logic [3:0]  r_cnt;
    logic        r_we;
    logic [1:0]  r_size;
    logic        r_unsigned;
    logic [31:0] r_addr;
    logic [31:0] r_wdata;
    logic        r_rsp_valid;
    logic [31:0] r_rsp_rdata;
    logic        r_rsp_err;
    logic        r_busy;

    logic [31:0]   w_words [DEPTH];
    logic [AW-1:0] w_idx;
    logic          w_oor;
    logic          w_err;
    logic          w_last;
    logic          w_commit;
    logic [3:0]    w_lane_mask;
    logic [31:0]   w_wdata_rep;
    logic [31:0]   w_word;
    logic [7:0]    w_byte;
    logic [15:0]   w_half;
    logic [31:0]   w_load;

    assign w_idx  = r_addr[AW+1:2];
    assign w_oor  = |r_addr[31:AW+2];
    assign w_err  = w_oor
                  | (r_size == 2'd3)
                  | ((r_size == 2'd1) & r_addr[0])
                  | ((r_size == 2'd2) & (r_addr[1:0] != 2'b00));

    // The counter is loaded with LATENCY and the move to RESP happens on the edge
    // after it reaches zero, so the response appears LATENCY+1 edges after accept.
    assign w_last   = (r_state == S_WAIT) && (r_cnt == 4'd0);
    assign w_commit = w_last && r_we && !w_err;

    // Lane enables and lane-replicated store data for the captured size/offset
    always_comb begin
        case (r_size)
            2'd0: begin
                w_lane_mask = 4'b0001 << r_addr[1:0];
                w_wdata_rep = {4{r_wdata[7:0]}};
            end
            2'd1: begin
                w_lane_mask = r_addr[1] ? 4'b1100 : 4'b0011;
                w_wdata_rep = {2{r_wdata[15:0]}};
            end
            default: begin
                w_lane_mask = 4'b1111;
                w_wdata_rep = r_wdata;
            end
        endcase
    end

    // Word storage: no reset, so committed stores survive a controller reset.
    // Each word powers up holding its own index.
    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_word
        logic [31:0] r_word = 32'(gi);

        // Byte-lane write of the addressed word on the commit edge
        always_ff @(posedge i_clk) begin
            if (w_commit && (w_idx == AW'(gi))) begin
                for (int l = 0; l < 4; l++) begin
                    if (w_lane_mask[l]) r_word[8*l +: 8] <= w_wdata_rep[8*l +: 8];
                end
            end
        end

        assign w_words[gi] = r_word;
    end

    assign w_word = w_words[w_idx];
    assign w_byte = w_word[{r_addr[1:0], 3'b000} +: 8];
    assign w_half = r_addr[1] ? w_word[31:16] : w_word[15:0];

    // Little-endian lane select with sign or zero extension; words pass through
    always_comb begin
        case (r_size)
            2'd0:    w_load = r_unsigned ? {24'd0, w_byte} : {{24{w_byte[7]}}, w_byte};
            2'd1:    w_load = r_unsigned ? {16'd0, w_half} : {{16{w_half[15]}}, w_half};
            default: w_load = w_word;
        endcase
    end

    // Control FSM: capture in IDLE, count down in WAIT, hold the response in RESP
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state     <= S_IDLE;
            r_cnt       <= 4'd0;
            r_we        <= 1'b0;
            r_size      <= 2'd0;
            r_unsigned  <= 1'b0;
            r_addr      <= 32'd0;
            r_wdata     <= 32'd0;
            r_rsp_valid <= 1'b0;
            r_rsp_rdata <= 32'd0;
            r_rsp_err   <= 1'b0;
            r_busy      <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (i_req_valid) begin
                        r_we       <= i_req_we;
                        r_size     <= i_req_size;
                        r_unsigned <= i_req_unsigned;
                        r_addr     <= i_req_addr;
                        r_wdata    <= i_req_wdata;
                        r_cnt      <= LAT;
                        r_busy     <= 1'b1;
                        r_state    <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (r_cnt == 4'd0) begin
                        r_rsp_valid <= 1'b1;
                        r_rsp_err   <= w_err;
                        r_rsp_rdata <= (w_err || r_we) ? 32'd0 : w_load;
                        r_state     <= S_RESP;
                    end else begin
                        r_cnt <= r_cnt - 4'd1;
                    end
                end
                S_RESP: begin
                    if (i_rsp_ready) begin
                        r_rsp_valid <= 1'b0;
                        r_rsp_rdata <= 32'd0;
                        r_rsp_err   <= 1'b0;
                        r_busy      <= 1'b0;
                        r_state     <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    // Ready only in IDLE and never while reset is held
    assign o_req_ready = (r_state == S_IDLE) && i_rst_n;
    assign o_rsp_valid = r_rsp_valid;
    assign o_rsp_rdata = r_rsp_rdata;
    assign o_rsp_err   = r_rsp_err;
    assign o_busy      = r_busy;

endmodule

// File: tb/tb_data_memory_ctrl.sv
// tb_data_memory_ctrl: directed and random load/store traffic against a
// cycle-count based reference model of the controller and its word array.
module tb_data_memory_ctrl;
    localparam int DEPTH = 128;
    localparam int LAT   = 2;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n;
    logic        req_valid, req_ready, req_we, req_unsigned;
    logic [1:0]  req_size;
    logic [31:0] req_addr, req_wdata;
    logic        rsp_valid, rsp_ready, rsp_err, busy;
    logic [31:0] rsp_rdata;

    logic        l0_req_valid, l0_req_ready, l0_rsp_valid, l0_rsp_ready, l0_rsp_err, l0_busy;
    logic [31:0] l0_rsp_rdata;

    data_memory_ctrl #(.DEPTH(DEPTH), .LATENCY(LAT)) dut (
        .i_clk(clk), .i_rst_n(rst_n),
        .i_req_valid(req_valid), .o_req_ready(req_ready), .i_req_we(req_we),
        .i_req_size(req_size), .i_req_unsigned(req_unsigned), .i_req_addr(req_addr),
        .i_req_wdata(req_wdata), .o_rsp_valid(rsp_valid), .i_rsp_ready(rsp_ready),
        .o_rsp_rdata(rsp_rdata), .o_rsp_err(rsp_err), .o_busy(busy)
    );

    data_memory_ctrl #(.DEPTH(DEPTH), .LATENCY(0)) dut0 (
        .i_clk(clk), .i_rst_n(rst_n),
        .i_req_valid(l0_req_valid), .o_req_ready(l0_req_ready), .i_req_we(1'b0),
        .i_req_size(2'd2), .i_req_unsigned(1'b0), .i_req_addr(32'h4),
        .i_req_wdata(32'd0), .o_rsp_valid(l0_rsp_valid), .i_rsp_ready(l0_rsp_ready),
        .o_rsp_rdata(l0_rsp_rdata), .o_rsp_err(l0_rsp_err), .o_busy(l0_busy)
    );

    int total  = 0;
    int passed = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    endtask

    // ---------------- reference model ----------------
    logic [31:0] mem [DEPTH];
    initial for (int i = 0; i < DEPTH; i++) mem[i] = 32'(i);

    bit          m_pend, m_resp, m_err;
    int          cyc, acc;
    logic        m_we, m_uns;
    logic [1:0]  m_size;
    logic [31:0] m_addr, m_wdata, m_rdata;

    function automatic bit is_err(input logic [1:0] size, input logic [31:0] addr);
        return (size == 2'd3) || (size == 2'd1 && addr[0]) ||
               (size == 2'd2 && addr[1:0] != 2'b00) || ((addr >> 2) >= 32'(DEPTH));
    endfunction

    // Execute the captured request against the model array
    function automatic void serve();
        int w, sh, nb;
        logic [31:0] word, v;
        m_err   = is_err(m_size, m_addr);
        m_rdata = 32'd0;
        if (!m_err) begin
            w    = int'(m_addr >> 2);
            sh   = 8 * int'(m_addr[1:0]);
            word = mem[w];
            if (m_we) begin
                nb = (m_size == 2'd0) ? 1 : (m_size == 2'd1) ? 2 : 4;
                for (int b = 0; b < nb; b++) word[(sh + 8*b) +: 8] = m_wdata[8*b +: 8];
                mem[w] = word;
            end else begin
                v = word >> sh;
                if (m_size == 2'd0)      m_rdata = m_uns ? {24'd0, v[7:0]}  : {{24{v[7]}}, v[7:0]};
                else if (m_size == 2'd1) m_rdata = m_uns ? {16'd0, v[15:0]} : {{16{v[15]}}, v[15:0]};
                else                     m_rdata = word;
            end
        end
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_pend = 1'b0;
            m_resp = 1'b0;
        end else begin
            cyc++;
            if (m_resp) begin
                if (rsp_ready) begin m_resp = 1'b0; m_pend = 1'b0; end
            end else if (m_pend) begin
                if (cyc == acc + LAT + 1) begin serve(); m_resp = 1'b1; end
            end else if (req_valid) begin
                m_pend = 1'b1; acc = cyc;
                m_we = req_we; m_size = req_size; m_uns = req_unsigned;
                m_addr = req_addr; m_wdata = req_wdata;
            end
        end
    end

    // Every-cycle comparison of the main DUT against the model
    always @(negedge clk) begin
        if (!rst_n) begin
            chk("rst_req_ready", 32'(req_ready), 32'd0);
            chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
            chk("rst_rsp_rdata", rsp_rdata, 32'd0);
            chk("rst_rsp_err",   32'(rsp_err), 32'd0);
            chk("rst_busy",      32'(busy), 32'd0);
        end else begin
            chk("req_ready", 32'(req_ready), 32'(!m_pend));
            chk("busy",      32'(busy), 32'(m_pend));
            chk("rsp_valid", 32'(rsp_valid), 32'(m_resp));
            chk("rsp_err",   32'(rsp_err), m_resp ? 32'(m_err) : 32'd0);
            chk("rsp_rdata", rsp_rdata, m_resp ? m_rdata : 32'd0);
        end
    end

    // ---------------- stimulus ----------------
    task automatic run_req(input logic we, input logic [1:0] size, input logic uns,
                           input logic [31:0] addr, input logic [31:0] wdata, input int hold,
                           input bit lit, input logic [31:0] lit_d, input logic lit_e);
        int n;
        @(posedge clk); #1;
        req_valid = 1'b1; req_we = we; req_size = size; req_unsigned = uns;
        req_addr = addr; req_wdata = wdata;
        @(posedge clk); #1;
        // Traffic while busy must be ignored
        req_valid = 1'($urandom); req_we = 1'($urandom); req_size = 2'($urandom);
        req_unsigned = 1'($urandom); req_addr = $urandom; req_wdata = $urandom;
        n = 0;
        while (!rsp_valid && n < 40) begin @(posedge clk); #1; n++; end
        chk("latency", 32'(n), 32'(LAT + 1));
        if (lit) begin
            chk("lit_rdata", rsp_rdata, lit_d);
            chk("lit_err", 32'(rsp_err), 32'(lit_e));
        end
        for (int h = 0; h < hold; h++) begin
            @(posedge clk); #1;
            chk("hold_valid", 32'(rsp_valid), 32'd1);
            chk("hold_ready", 32'(req_ready), 32'd0);
        end
        rsp_ready = 1'b1;
        @(posedge clk); #1;
        rsp_ready = 1'b0; req_valid = 1'b0;
        chk("hs_valid", 32'(rsp_valid), 32'd0);
        chk("hs_ready", 32'(req_ready), 32'd1);
    endtask

    initial begin
        logic [31:0] a;
        int n;
        rst_n = 1'b0;
        req_valid = 0; req_we = 0; req_size = 0; req_unsigned = 0; req_addr = 0; req_wdata = 0;
        rsp_ready = 0; l0_req_valid = 0; l0_rsp_ready = 0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        #1 chk("ready_after_release", 32'(req_ready), 32'd1);

        // Zero-latency build: response on the edge after accept
        @(posedge clk); #1 l0_req_valid = 1'b1;
        @(posedge clk); #1 l0_req_valid = 1'b0;
        chk("l0_no_early_valid", 32'(l0_rsp_valid), 32'd0);
        chk("l0_busy", 32'(l0_busy), 32'd1);
        @(posedge clk); #1;
        chk("l0_valid", 32'(l0_rsp_valid), 32'd1);
        chk("l0_rdata", l0_rsp_rdata, 32'h1);
        chk("l0_err", 32'(l0_rsp_err), 32'd0);
        l0_rsp_ready = 1'b1;
        @(posedge clk); #1 l0_rsp_ready = 1'b0;
        chk("l0_hs_valid", 32'(l0_rsp_valid), 32'd0);
        chk("l0_hs_ready", 32'(l0_req_ready), 32'd1);

        // Literal expectations
        run_req(0, 2'd2, 0, 32'h10, 0, 0, 1, 32'h00000004, 0);
        run_req(1, 2'd0, 0, 32'h21, 32'hAB, 0, 1, 32'h0, 0);
        run_req(0, 2'd2, 0, 32'h20, 0, 0, 1, 32'h0000AB08, 0);
        run_req(0, 2'd0, 0, 32'h21, 0, 0, 1, 32'hFFFFFFAB, 0);
        run_req(0, 2'd0, 1, 32'h21, 0, 0, 1, 32'h000000AB, 0);
        run_req(0, 2'd2, 0, 32'h22, 0, 0, 1, 32'h0, 1);
        run_req(1, 2'd1, 0, 32'h03, 32'hFFFF, 0, 1, 32'h0, 1);
        run_req(0, 2'd2, 0, 32'h200, 0, 0, 1, 32'h0, 1);
        run_req(0, 2'd3, 0, 32'h00, 0, 0, 1, 32'h0, 1);
        run_req(0, 2'd2, 0, 32'h00, 0, 0, 1, 32'h00000000, 0);
        run_req(0, 2'd2, 0, 32'h1FC, 0, 0, 1, 32'h0000007F, 0);
        run_req(0, 2'd2, 0, 32'h30, 0, 5, 1, 32'h0000000C, 0);

        // Reset in WAIT drops an uncommitted store
        @(posedge clk); #1;
        req_valid = 1; req_we = 1; req_size = 2'd2; req_addr = 32'h40; req_wdata = 32'hDEADBEEF;
        @(posedge clk); #1 req_valid = 0;
        @(posedge clk); #1 rst_n = 1'b0;
        #1 chk("rst_wait_valid", 32'(rsp_valid), 32'd0);
        chk("rst_wait_busy", 32'(busy), 32'd0);
        @(posedge clk); #1 rst_n = 1'b1;
        run_req(0, 2'd2, 0, 32'h40, 0, 0, 1, 32'h00000010, 0);

        // Reset in RESP drops the pending response
        @(posedge clk); #1;
        req_valid = 1; req_we = 0; req_size = 2'd2; req_addr = 32'h44;
        @(posedge clk); #1 req_valid = 0;
        n = 0;
        while (!rsp_valid && n < 40) begin @(posedge clk); #1; n++; end
        chk("resp_reached", 32'(rsp_valid), 32'd1);
        rst_n = 1'b0;
        #1 chk("rst_resp_valid", 32'(rsp_valid), 32'd0);
        chk("rst_resp_rdata", rsp_rdata, 32'd0);
        @(posedge clk); #1 rst_n = 1'b1;
        for (int k = 0; k < 4; k++) begin
            @(posedge clk); #1 chk("no_stale_valid", 32'(rsp_valid), 32'd0);
        end

        // Random traffic
        for (int t = 0; t < 200; t++) begin
            a = 32'($urandom_range(0, 639));
            if ($urandom_range(0, 15) == 0) a = $urandom;
            run_req(1'($urandom), 2'($urandom), 1'($urandom), a, $urandom,
                    int'($urandom_range(0, 3)), 0, 32'd0, 1'b0);
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
